down_timer: RTL and testbench
=============================

# down_timer

Loadable down-counting timer, the counting-down counterpart of the existing up and up/down counters. Software or a controlling FSM loads a start value, starts the timer and receives a one-cycle `done` pulse when the count reaches zero. It sits beside the counters in the common library and serves as the timeout, delay and baud-interval source for protocol blocks. An optional auto-reload mode makes it a periodic tick generator.

## Interface
- `Size`, 8: counter width in bits, at least 2.
- `Prescale`, 1: clock cycles per decrement, at least 1. A value of 1 means decrement every cycle.

- `clock`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `load`  in  1  capture `data_i` into the count and the reload register.
- `data_i`  in  `Size`  load value.
- `start`  in  1  begin counting.
- `abort`  in  1  stop counting without signalling completion.
- `data_o`  out  `Size`  current count, registered.
- `busy`  out  1  high while in state Run, registered.
- `done`  out  1  one-cycle pulse on expiry, registered.

## Operation
- States: Idle and Run. Reset puts the block in Idle with `data_o`=0, reload register=0, `busy`=0, `done`=0 and the prescaler at 0.
- **Idle:**
  - `load`=1 sets `data_o` and the reload register to `data_i`.
  - `start`=1 with an effective count ≠ 0 moves to Run. The effective count is `data_i` if `load` is also high, otherwise `data_o`.
  - `start`=1 with an effective count of 0 pulses `done` for one cycle and stays in Idle.
- **Run:**
  - The prescaler counts 0..`Prescale`−1. A tick occurs on the cycle it wraps.
  - On a tick with `data_o`>1, `data_o` decrements by 1.
  - On a tick with `data_o`=1, `data_o` becomes 0, `done` pulses and the state returns to Idle.
  - `load` and `start` are ignored while in Run.
- **`abort` in Run:** the state returns to Idle, `data_o` holds its current value and the prescaler clears. `done` does not pulse.
  - If `abort` and a terminal tick fall on the same cycle, `abort` wins: no decrement and no `done`.
- **`abort` in Idle:** no effect.
- **Priority in Idle:** `load` > `start`. Both on the same cycle means load and start with the new value.
- **Width rules:** `data_o` never wraps below 0. The maximum count is 2^`Size`−1.
- **Reset mid-run:** returns to the reset values on the next edge. Any pending `done` is dropped.

## Timing
- `start` sampled at edge N: `busy`=1 after edge N and the prescaler is cleared.
- First decrement at edge N+`Prescale`.
- For a start value V: `done`=1 and `busy`=0 after edge N+V·`Prescale`, with `done` lasting exactly one cycle.
- A new `start` is accepted on the cycle `done` is high, because the state is already Idle.
- Zero-value start: `done` is high after edge N, and `busy` stays 0.
- `load` to `data_o` visible: 1 cycle.

## Configuration
- Macro: `DOWN_TIMER_RELOAD_EN`.
- **Defined:** on a terminal tick in Run with reload register ≠ 0:
  - `data_o` is set to the reload register, `done` pulses and the state stays Run.
  - The period is reload·`Prescale` cycles, with no gap cycle.
  - `abort` is the only exit from Run.
  - A reload register of 0 behaves as in the undefined case.
- **Undefined:** one-shot only. The reload register is still written by `load` but is unused.

## Structure
- Shared package `down_timer_pkg` holds the state encoding constants (`DT_IDLE`, `DT_RUN`) and the minimum-width checks for `Size` and `Prescale`.
- Sub-module `down_timer_prescaler`:
  - Inputs: `clock`, `reset`, `clear`, `enable`. Output: `tick`.
  - Parameterised by `Prescale`.
  - With `Prescale`=1, `tick` equals `enable`.
- The top level holds the FSM, the count register, the reload register and the `done` register.

## Test plan
- `Prescale`=1: load 5, start at edge N -> `data_o` goes 4,3,2,1,0 on edges N+1..N+5. `done`=1 only after N+5, and `busy` falls at N+5.
- `Prescale`=4: load 3, start -> decrements at N+4, N+8 and N+12, with `done` at N+12 for one cycle.
- Load 0 then start -> `done` is high for one cycle after the start edge and `busy` is never 1. Separately, `load`=1 and `start`=1 together with `data_i`=2 -> runs and `done` after 2 cycles.
- Load 3, start, `abort` on the cycle where `data_o`=1 and the tick fires -> Idle, `data_o`=1, no `done`. A following `start` finishes one tick later.
- `DOWN_TIMER_RELOAD_EN` defined: load 2, start, `Prescale`=1 -> `done` at N+2, N+4, N+6 with `busy` held high. `abort` -> `busy`=0 next edge.
- Reset asserted mid-run with `data_o`=7 -> after the next edge `data_o`=0, `busy`=0, `done`=0. A `load`/`start` during Run changes nothing.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: state encoding and parameter sanity limits.
package down_timer_pkg;

  typedef enum logic {
    DT_IDLE = 1'b0,
    DT_RUN  = 1'b1
  } dt_state_t;

  localparam int DT_MIN_SIZE     = 2;
  localparam int DT_MIN_PRESCALE = 1;

  function automatic bit dt_params_ok(input int size, input int prescale);
    return (size >= DT_MIN_SIZE) && (prescale >= DT_MIN_PRESCALE);
  endfunction

endpackage

// File: rtl/down_timer_prescaler.sv
// Divides the clock into one tick every Prescale enabled cycles; clear forces the phase to zero.
// With Prescale=1 the phase counter is pinned at zero, so tick follows enable directly.
module down_timer_prescaler #(
  parameter int Prescale = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CntW = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [CntW-1:0] LastPhase = CntW'(Prescale - 1);

  logic [CntW-1:0] r_phase;
  logic            w_wrap;

  assign w_wrap = (r_phase == LastPhase);
  assign tick   = enable && w_wrap;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_phase <= '0;
    end else if (enable) begin
      r_phase <= w_wrap ? '0 : r_phase + CntW'(1);
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with a one-cycle done pulse on expiry.
// Optional periodic auto-reload is enabled with the DOWN_TIMER_RELOAD_EN macro.
module down_timer #(
  parameter int Size     = 8,
  parameter int Prescale = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [Size-1:0] data_i,
  input  logic            start,
  input  logic            abort,
  output logic [Size-1:0] data_o,
  output logic            busy,
  output logic            done
);

  import down_timer_pkg::*;

  if (!dt_params_ok(Size, Prescale)) begin : g_param_check
    $error("down_timer: Size must be >= 2 and Prescale >= 1");
  end

  dt_state_t       r_state, w_state_nxt;
  logic [Size-1:0] r_count, w_count_nxt;
  logic [Size-1:0] r_reload, w_reload_nxt;
  logic            r_done, w_done_nxt;
  logic [Size-1:0] w_eff_count;
  logic            w_clear, w_enable, w_tick;

  down_timer_prescaler #(
    .Prescale(Prescale)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .enable(w_enable),
    .tick  (w_tick)
  );

  assign w_eff_count = load ? data_i : r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= DT_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    w_clear      = 1'b0;
    w_enable     = 1'b0;
    unique case (r_state)
      DT_IDLE: begin
        // Holding the prescaler clear means the first tick lands exactly Prescale cycles after start.
        w_clear = 1'b1;
        if (load) begin
          w_count_nxt  = data_i;
          w_reload_nxt = data_i;
        end
        if (start) begin
          if (w_eff_count != '0) begin
            w_state_nxt = DT_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      DT_RUN: begin
        if (abort) begin
          w_state_nxt = DT_IDLE;
          w_clear     = 1'b1;
        end else begin
          w_enable = 1'b1;
          if (w_tick) begin
            if (r_count > Size'(1)) begin
              w_count_nxt = r_count - Size'(1);
            end else begin
              w_done_nxt = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
              if (r_reload != '0) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = '0;
                w_state_nxt = DT_IDLE;
              end
`else
              w_count_nxt = '0;
              w_state_nxt = DT_IDLE;
`endif
            end
          end
        end
      end
      default: begin
        w_state_nxt = DT_IDLE;
      end
    endcase
  end

  assign data_o = r_count;
  assign busy   = (r_state == DT_RUN);
  assign done   = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: two instances (Prescale 1 and 4) share one directed stimulus stream
// and are checked every cycle against an elapsed-time model, plus hand-computed spot values.
module tb_down_timer;

  logic       clock = 1'b0;
  logic       reset, load, start, abort;
  logic [7:0] data_i;
  logic [7:0] d1, d4;
  logic       b1, b4, dn1, dn4;

  int vectors = 0;
  int miscompares = 0;

`ifdef DOWN_TIMER_RELOAD_EN
  localparam bit ReloadEn = 1'b1;
`else
  localparam bit ReloadEn = 1'b0;
`endif

  always #5 clock = ~clock;

  down_timer #(.Size(8), .Prescale(1)) u_dut1 (
    .clock(clock), .reset(reset), .load(load), .data_i(data_i), .start(start),
    .abort(abort), .data_o(d1), .busy(b1), .done(dn1)
  );

  down_timer #(.Size(8), .Prescale(4)) u_dut4 (
    .clock(clock), .reset(reset), .load(load), .data_i(data_i), .start(start),
    .abort(abort), .data_o(d4), .busy(b4), .done(dn4)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: while running, the count is derived from cycles elapsed since the start edge.
  int  m_count[2], m_reload[2], m_t0[2], m_v[2];
  bit  m_busy[2], m_done[2];
  int  cyc = 0;
  bit  m_ok = 1'b0;

  task automatic step(input int k);
    int p, e, e2, r;
    p = (k == 0) ? 1 : 4;
    if (reset) begin
      m_count[k] = 0; m_reload[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      return;
    end
    m_done[k] = 0;
    if (!m_busy[k]) begin
      if (load) begin
        m_count[k]  = int'(data_i);
        m_reload[k] = int'(data_i);
      end
      if (start) begin
        if (m_count[k] != 0) begin
          m_busy[k] = 1; m_t0[k] = cyc; m_v[k] = m_count[k];
        end else begin
          m_done[k] = 1;
        end
      end
    end else if (abort) begin
      m_busy[k] = 0;
    end else begin
      e = cyc - m_t0[k];
      if (e < m_v[k] * p) begin
        m_count[k] = m_v[k] - e / p;
      end else if (ReloadEn && m_reload[k] != 0) begin
        e2 = e - m_v[k] * p;
        r  = e2 % (m_reload[k] * p);
        m_count[k] = (r == 0) ? m_reload[k] : m_reload[k] - r / p;
        m_done[k]  = (r == 0);
      end else begin
        m_count[k] = 0; m_done[k] = 1; m_busy[k] = 0;
      end
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    for (int k = 0; k < 2; k++) step(k);
    if (reset) m_ok = 1'b1;
  end

  always @(negedge clock) begin
    if (m_ok) begin
      chk("model p1 data_o", int'(d1), m_count[0]);
      chk("model p1 busy", int'(b1), int'(m_busy[0]));
      chk("model p1 done", int'(dn1), int'(m_done[0]));
      chk("model p4 data_o", int'(d4), m_count[1]);
      chk("model p4 busy", int'(b4), int'(m_busy[1]));
      chk("model p4 done", int'(dn4), int'(m_done[1]));
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1; load = 0; start = 0; abort = 0; data_i = '0;
    nclk(2);
    chk("reset p1 data_o", int'(d1), 0);
    chk("reset p1 busy", int'(b1), 0);
    chk("reset p1 done", int'(dn1), 0);
    chk("reset p4 data_o", int'(d4), 0);
    reset = 0;

    // Prescale 1: load 5, start, count 4..0
    load = 1; data_i = 8'd5; nclk(1); load = 0;
    chk("t1 load visible", int'(d1), 5);
    start = 1; nclk(1); start = 0;
    chk("t1 busy at N", int'(b1), 1);
    chk("t1 data at N", int'(d1), 5);
    nclk(1); chk("t1 data N+1", int'(d1), 4);
    nclk(3); chk("t1 data N+4", int'(d1), 1);
    chk("t1 done N+4", int'(dn1), 0);
    nclk(1); chk("t1 data N+5", int'(d1), 0);
    chk("t1 done N+5", int'(dn1), 1);
    chk("t1 busy N+5", int'(b1), 0);
    nclk(1); chk("t1 done N+6", int'(dn1), 0);
    nclk(20);

    // Prescale 4: load 3, decrements at N+4, N+8, N+12
    load = 1; data_i = 8'd3; nclk(1); load = 0;
    start = 1; nclk(1); start = 0;
    nclk(3); chk("t2 data N+3", int'(d4), 3);
    nclk(1); chk("t2 data N+4", int'(d4), 2);
    nclk(4); chk("t2 data N+8", int'(d4), 1);
    nclk(4); chk("t2 data N+12", int'(d4), 0);
    chk("t2 done N+12", int'(dn4), 1);
    chk("t2 busy N+12", int'(b4), 0);
    nclk(1); chk("t2 done N+13", int'(dn4), 0);

    // Zero-value start, then simultaneous load+start
    load = 1; data_i = 8'd0; nclk(1); load = 0;
    start = 1; nclk(1); start = 0;
    chk("t3 zero done p1", int'(dn1), 1);
    chk("t3 zero busy p1", int'(b1), 0);
    chk("t3 zero done p4", int'(dn4), 1);
    nclk(1); chk("t3 zero done after", int'(dn1), 0);
    load = 1; start = 1; data_i = 8'd2; nclk(1); load = 0; start = 0;
    chk("t3 ls busy N", int'(b1), 1);
    nclk(1); chk("t3 ls data N+1", int'(d1), 1);
    nclk(1); chk("t3 ls done N+2", int'(dn1), 1);
    chk("t3 ls busy N+2", int'(b1), 0);
    nclk(10);

    // Abort in Idle does nothing; abort on the terminal tick wins
    abort = 1; nclk(1); abort = 0;
    load = 1; data_i = 8'd3; nclk(1); load = 0;
    start = 1; nclk(1); start = 0;
    nclk(2); chk("t4 data N+2", int'(d1), 1);
    abort = 1; nclk(1); abort = 0;
    chk("t4 abort busy", int'(b1), 0);
    chk("t4 abort data", int'(d1), 1);
    chk("t4 abort no done", int'(dn1), 0);
    nclk(1); chk("t4 no late done", int'(dn1), 0);
    start = 1; nclk(1); start = 0;
    chk("t4 restart busy", int'(b1), 1);
    nclk(1); chk("t4 restart done", int'(dn1), 1);
    chk("t4 restart data", int'(d1), 0);
    nclk(14);

    // Load 2, start: periodic with reload, one-shot otherwise
    load = 1; data_i = 8'd2; nclk(1); load = 0;
    start = 1; nclk(1); start = 0;
`ifdef DOWN_TIMER_RELOAD_EN
    for (int i = 0; i < 3; i++) begin
      nclk(1); chk("t5 gap done", int'(dn1), 0);
      chk("t5 gap busy", int'(b1), 1);
      nclk(1); chk("t5 period done", int'(dn1), 1);
      chk("t5 period busy", int'(b1), 1);
      chk("t5 period data", int'(d1), 2);
    end
    abort = 1; nclk(1); abort = 0;
    chk("t5 abort busy", int'(b1), 0);
`else
    nclk(1); chk("t5 data N+1", int'(d1), 1);
    nclk(1); chk("t5 done N+2", int'(dn1), 1);
    chk("t5 busy N+2", int'(b1), 0);
    abort = 1; nclk(1); abort = 0;
`endif
    nclk(12);

    // Reset mid-run; load/start during Run ignored
    load = 1; data_i = 8'd9; nclk(1); load = 0;
    start = 1; nclk(1); start = 0;
    nclk(1);
    load = 1; start = 1; data_i = 8'd200; nclk(1); load = 0; start = 0;
    chk("t6 run ignores load p1", int'(d1), 7);
    chk("t6 run busy p1", int'(b1), 1);
    chk("t6 run ignores load p4", int'(d4), 9);
    reset = 1; nclk(1); reset = 0;
    chk("t6 reset data p1", int'(d1), 0);
    chk("t6 reset busy p1", int'(b1), 0);
    chk("t6 reset done p1", int'(dn1), 0);
    chk("t6 reset data p4", int'(d4), 0);
    chk("t6 reset busy p4", int'(b4), 0);
    nclk(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
